adder_nbit_serial: RTL and testbench

ADDER_NBIT_SERIAL -- requirements
Module: adder_nbit_serial

---
 rtl/adder_nbit_serial.sv | 120 ++++++++++++
 tb/tb_adder_nbit_serial.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_serial.sv
// Bit-serial (STEP bits per cycle) adder with valid/ready handshakes on operands and result.
// Computes A+B+cin mod 2^WIDTH, carry-out and signed overflow in exactly WIDTH/STEP cycles.
module adder_nbit_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_num_a,
  input  logic [WIDTH-1:0] i_num_b,
  input  logic             i_cry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_cry,
  output logic             o_ovf
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_cry;
  logic             r_sa;
  logic             r_sb;
  logic             r_valid;
  logic             r_ready;
  logic             r_cout;
  logic             r_ovf;

  logic [STEP:0]    w_step;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_ovf;

  // Each step's sum enters at the MSB end; after NSTEP shifts w_acc_next is the full result.
  always_comb begin
    w_step     = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + {{STEP{1'b0}}, r_cry};
    w_acc_next = WIDTH'({w_step[STEP-1:0], r_acc} >> STEP);
    w_last     = (r_cnt == CW'(NSTEP - 1));
    w_ovf      = (r_sa == r_sb) && (w_acc_next[WIDTH-1] != r_sa);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_cry   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_a     <= i_num_a;
            r_b     <= i_num_b;
            r_sa    <= i_num_a[WIDTH-1];
            r_sb    <= i_num_b[WIDTH-1];
            r_cry   <= i_cry;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_a   <= r_a >> STEP;
          r_b   <= r_b >> STEP;
          r_acc <= w_acc_next;
          r_cry <= w_step[STEP];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_res   <= w_acc_next;
            r_cout  <= w_step[STEP];
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means a new operand can only be taken on the following edge.
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_res   = r_res;
  assign o_cry   = r_cout;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_nbit_serial.sv
// Directed and random checks of adder_nbit_serial, two instances (STEP=1 and STEP=4) fed in lockstep.
module tb_adder_nbit_serial;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_num_a;
  logic [7:0] i_num_b;
  logic       i_cry;

  logic       o_ready1, o_valid1, o_cry1, o_ovf1;
  logic [7:0] o_res1;
  logic       o_ready4, o_valid4, o_cry4, o_ovf4;
  logic [7:0] o_res4;

  int total = 0;
  int bad   = 0;

  adder_nbit_serial #(.WIDTH(8), .STEP(1)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready1),
    .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry),
    .o_valid(o_valid1), .i_ready(i_ready), .o_res(o_res1), .o_cry(o_cry1), .o_ovf(o_ovf1)
  );

  adder_nbit_serial #(.WIDTH(8), .STEP(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready4),
    .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry),
    .o_valid(o_valid4), .i_ready(i_ready), .o_res(o_res4), .o_cry(o_cry4), .o_ovf(o_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cry;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    i_num_a = a;
    i_num_b = b;
    i_cry   = cin;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_num_a = 8'($urandom);
    i_num_b = 8'($urandom);
    i_cry   = 1'($urandom);
    chk("accept_ready1", o_ready1, 0);
    chk("accept_ready4", o_ready4, 0);
  endtask

  task automatic wait_check(input logic [7:0] eres, input logic ecry, input logic eovf);
    int lat1;
    int lat4;
    lat1 = 0;
    lat4 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (o_valid4 && lat4 == 0) lat4 = c;
      if (o_valid1 && lat1 == 0) begin
        lat1 = c;
        break;
      end
    end
    chk("latency1", lat1, 8);
    chk("latency4", lat4, 2);
    chk("res1", o_res1, eres);
    chk("cry1", o_cry1, ecry);
    chk("ovf1", o_ovf1, eovf);
    chk("res4", o_res4, eres);
    chk("cry4", o_cry4, ecry);
    chk("ovf4", o_ovf4, eovf);
  endtask

  task automatic handshake();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("hs_valid1", o_valid1, 0);
    chk("hs_ready1", o_ready1, 1);
    chk("hs_valid4", o_valid4, 0);
    chk("hs_ready4", o_ready4, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] eres, input logic ecry, input logic eovf);
    start_op(a, b, cin);
    wait_check(eres, ecry, eovf);
    handshake();
  endtask

  initial begin
    logic [8:0] s;
    logic [7:0] ra, rb;
    logic       rc, rovf;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'hC0, 8'hC0, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[9] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0};

    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_num_a = '0;
    i_num_b = '0;
    i_cry   = 1'b0;
    #2 i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready1", o_ready1, 1);
    chk("rst_valid1", o_valid1, 0);
    chk("rst_res1", o_res1, 0);
    chk("rst_cry1", o_cry1, 0);
    chk("rst_ovf1", o_ovf1, 0);
    chk("rst_ready4", o_ready4, 1);
    chk("rst_valid4", o_valid4, 0);
    @(negedge clk);
    i_rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cry, vecs[i].ovf);

    // Result held in DONE while downstream stalls
    start_op(8'h12, 8'h34, 1'b0);
    wait_check(8'h46, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid1", o_valid1, 1);
      chk("stall_res1", o_res1, 8'h46);
      chk("stall_ready1", o_ready1, 0);
      chk("stall_valid4", o_valid4, 1);
      chk("stall_res4", o_res4, 8'h46);
    end
    // Operand offered during the handshake edge must not be taken until the next edge
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_num_a = 8'h21;
    i_num_b = 8'h10;
    i_cry   = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("hs_noacc_ready1", o_ready1, 1);
    chk("hs_noacc_valid1", o_valid1, 0);
    chk("hold_res1", o_res1, 8'h46);
    chk("hs_noacc_ready4", o_ready4, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("next_acc_ready1", o_ready1, 0);
    chk("next_acc_ready4", o_ready4, 0);
    wait_check(8'h32, 1'b0, 1'b0);
    handshake();

    // Reset in the middle of a calculation
    start_op(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #3 i_rst = 1'b1;
    #1;
    chk("midrst_res1", o_res1, 0);
    chk("midrst_cry1", o_cry1, 0);
    chk("midrst_ovf1", o_ovf1, 0);
    chk("midrst_valid1", o_valid1, 0);
    chk("midrst_ready1", o_ready1, 1);
    chk("midrst_res4", o_res4, 0);
    chk("midrst_valid4", o_valid4, 0);
    chk("midrst_ready4", o_ready4, 1);
    @(negedge clk);
    i_rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("discard_valid1", o_valid1, 0);
    chk("discard_ready1", o_ready1, 1);
    run_op(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      s    = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf = (ra[7] == rb[7]) && (s[7] != ra[7]);
      run_op(ra, rb, rc, s[7:0], s[8], rovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
